// File: rtl/jt51_sh_ctrl.sv
// Access controller for a recirculating shift-register bank: clears it after reset,
// tracks the head slot and serialises single-slot read/write requests onto their slot time.
module jt51_sh_ctrl #(
    parameter  int WIDTH  = 5,
    parameter  int STAGES = 32,
    localparam int SLOT_W = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              req,
    input  logic              we,
    input  logic [SLOT_W-1:0] slot,
    input  logic [WIDTH-1:0]  wdata,
    output logic              busy,
    output logic              ack,
    output logic              err,
    output logic [WIDTH-1:0]  rdata,
    output logic [SLOT_W-1:0] slot_cnt,
    output logic              sync,
    output logic              sh_en,
    output logic              sh_ld,
    output logic [WIDTH-1:0]  sh_din,
    input  logic [WIDTH-1:0]  sh_drop
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [SLOT_W:0]   STAGES_V = (SLOT_W+1)'(STAGES);
    localparam logic [SLOT_W-1:0] LAST     = SLOT_W'(STAGES - 1);

    state_t              state, state_nx;
    logic                we_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [WIDTH-1:0]    wdata_q;
    logic                err_q;
    logic                last_slot;
    logic                hit;
    logic                slot_bad;

    assign last_slot = (slot_cnt == LAST);
    assign hit       = cen & (slot_cnt == slot_q);
    assign slot_bad  = ({1'b0, slot} >= STAGES_V);
    assign sh_en     = cen & ~rst;
    assign sync      = (slot_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            slot_cnt <= '0;
            rdata    <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (cen) begin
                slot_cnt <= last_slot ? '0 : slot_cnt + SLOT_W'(1);
            end
            if (state == IDLE && req) begin
                we_q    <= we;
                slot_q  <= slot;
                wdata_q <= wdata;
                err_q   <= slot_bad;
            end
            if (state == WAIT && !we_q && hit) begin
                rdata <= sh_drop;
            end
        end
    end

    // Load controls depend only on registered state and cen, never on req.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        ack      = 1'b0;
        err      = 1'b0;
        sh_ld    = 1'b0;
        sh_din   = '0;
        unique case (state)
            CLEAR: begin
                sh_ld = 1'b1;
                if (cen && last_slot) state_nx = IDLE;
            end
            IDLE: begin
                busy = 1'b0;
                if (req) state_nx = slot_bad ? DONE : WAIT;
            end
            WAIT: begin
                sh_din = wdata_q;
                sh_ld  = we_q & hit;
                if (hit) state_nx = DONE;
            end
            DONE: begin
                ack      = 1'b1;
                err      = err_q;
                state_nx = IDLE;
            end
            default: state_nx = CLEAR;
        endcase
    end

endmodule

// File: tb/tb_jt51_sh_ctrl.sv
// Scoreboard bench for jt51_sh_ctrl: a 32-slot and a 24-slot instance, each driving a
// behavioural shift bank; expected acks are queued at request acceptance and popped on ack.
module tb_jt51_sh_ctrl;

    localparam int W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, cen = 1'b1, req = 1'b0, we = 1'b0;
    logic [4:0] slot = '0, wdata = '0;
    logic       busy, ack, err, sync, sh_en, sh_ld;
    logic [4:0] rdata, slot_cnt, sh_din, sh_drop;

    logic       rst_b = 1'b1, cen_b = 1'b1, req_b = 1'b0, we_b = 1'b0;
    logic [4:0] slot_b = '0, wdata_b = '0;
    logic       busy_b, ack_b, err_b, sync_b, sh_en_b, sh_ld_b;
    logic [4:0] rdata_b, slot_cnt_b, sh_din_b, sh_drop_b;

    jt51_sh_ctrl #(.WIDTH(W), .STAGES(32)) dut (
        .clk(clk), .rst(rst), .cen(cen), .req(req), .we(we), .slot(slot), .wdata(wdata),
        .busy(busy), .ack(ack), .err(err), .rdata(rdata), .slot_cnt(slot_cnt), .sync(sync),
        .sh_en(sh_en), .sh_ld(sh_ld), .sh_din(sh_din), .sh_drop(sh_drop)
    );

    jt51_sh_ctrl #(.WIDTH(W), .STAGES(24)) dut_b (
        .clk(clk), .rst(rst_b), .cen(cen_b), .req(req_b), .we(we_b), .slot(slot_b), .wdata(wdata_b),
        .busy(busy_b), .ack(ack_b), .err(err_b), .rdata(rdata_b), .slot_cnt(slot_cnt_b), .sync(sync_b),
        .sh_en(sh_en_b), .sh_ld(sh_ld_b), .sh_din(sh_din_b), .sh_drop(sh_drop_b)
    );

    // Behavioural banks: head is element 0, the shifted-out head re-enters at the tail.
    logic [4:0] bank [32];
    logic [4:0] bank_b [24];
    assign sh_drop   = bank[0];
    assign sh_drop_b = bank_b[0];

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 5'(i) ^ 5'h15;
        for (int i = 0; i < 24; i++) bank_b[i] = 5'(i) ^ 5'h0B;
    end

    always @(posedge clk) begin
        if (sh_en) begin
            for (int i = 0; i < 31; i++) bank[i] <= bank[i+1];
            bank[31] <= sh_ld ? sh_din : bank[0];
        end
        if (sh_en_b) begin
            for (int i = 0; i < 23; i++) bank_b[i] <= bank_b[i+1];
            bank_b[23] <= sh_ld_b ? sh_din_b : bank_b[0];
        end
    end

    int ld_cnt = 0;
    int ld_cnt_b = 0;
    always @(posedge clk) begin
        if (sh_en && sh_ld) ld_cnt <= ld_cnt + 1;
        if (sh_en_b && sh_ld_b) ld_cnt_b <= ld_cnt_b + 1;
    end

    int cen_div = 1;
    int cen_ph  = 0;
    always @(negedge clk) begin
        cen_ph = cen_ph + 1;
        cen    = ((cen_ph % cen_div) == 0);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    typedef struct {
        logic       rd;
        logic       e;
        logic [4:0] d;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always @(negedge clk) begin : mon_a
        exp_t x;
        if (ack === 1'b1) begin
            if (qa.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack_a: got ack, required none");
            end else begin
                x = qa.pop_front();
                chk("err_a", 32'(err), 32'(x.e));
                if (x.rd) chk("rdata_a", 32'(rdata), 32'(x.d));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t x;
        if (ack_b === 1'b1) begin
            if (qb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack_b: got ack, required none");
            end else begin
                x = qb.pop_front();
                chk("err_b", 32'(err_b), 32'(x.e));
                if (x.rd) chk("rdata_b", 32'(rdata_b), 32'(x.d));
            end
        end
    end

    task automatic send(input bit b, input logic w, input logic [4:0] s, input logic [4:0] d,
                        input logic e, input logic [4:0] xd, input int align);
        int t = 0;
        logic bz;
        logic [4:0] sc;
        exp_t x;
        do begin
            @(negedge clk);
            t++;
            bz = b ? busy_b : busy;
            sc = b ? slot_cnt_b : slot_cnt;
        end while ((bz !== 1'b0 || (align >= 0 && int'(sc) != align)) && t < 2000);
        if (t >= 2000) begin
            timeout("send_idle");
            return;
        end
        if (b) begin req_b = 1'b1; we_b = w; slot_b = s; wdata_b = d; end
        else   begin req   = 1'b1; we   = w; slot   = s; wdata   = d; end
        @(posedge clk);
        #1;
        x.rd = !w;
        x.e  = e;
        x.d  = xd;
        if (b) begin req_b = 1'b0; qb.push_back(x); end
        else   begin req   = 1'b0; qa.push_back(x); end
    endtask

    task automatic wait_ack(input bit b, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while ((b ? ack_b : ack) !== 1'b1 && lat < 1000);
        if (lat >= 1000) timeout("wait_ack");
    endtask

    task automatic op(input bit b, input logic w, input logic [4:0] s, input logic [4:0] d,
                      input logic [4:0] xd);
        int lat;
        send(b, w, s, d, 1'b0, xd, -1);
        wait_ack(b, lat);
    endtask

    task automatic wait_idle(input bit b, input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((b ? busy_b : busy) !== 1'b0 && t < 2000);
        if (t >= 2000) timeout(name);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        // T1: reset state, then the post-reset clear sweep.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_slot_cnt", 32'(slot_cnt), 32'd0);
        chk("rst_sync", 32'(sync), 32'd1);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_sh_en", 32'(sh_en), 32'd0);
        ld_cnt   = 0;
        ld_cnt_b = 0;
        rst   = 1'b0;
        rst_b = 1'b0;
        wait_idle(1'b0, "clear_a");
        wait_idle(1'b1, "clear_b");
        chk("clear_loads_a", 32'(ld_cnt), 32'd32);
        chk("clear_loads_b", 32'(ld_cnt_b), 32'd24);
        for (int i = 0; i < 32; i++) op(1'b0, 1'b0, 5'(i), 5'h00, 5'h00);

        // T2: write then read back, neighbours untouched.
        op(1'b0, 1'b1, 5'd5, 5'h1A, 5'h00);
        op(1'b0, 1'b0, 5'd5, 5'h00, 5'h1A);
        op(1'b0, 1'b0, 5'd4, 5'h00, 5'h00);
        op(1'b0, 1'b0, 5'd6, 5'h00, 5'h00);

        // T3: acceptance at slot 3 waits a full loop; at slot 2 hits on the next tick.
        send(1'b0, 1'b1, 5'd3, 5'h0C, 1'b0, 5'h00, 3);
        wait_ack(1'b0, lat);
        chk("hit_full_loop", 32'(lat - 1), 32'd32);
        send(1'b0, 1'b0, 5'd3, 5'h00, 1'b0, 5'h0C, 2);
        wait_ack(1'b0, lat);
        chk("hit_next_tick", 32'(lat - 1), 32'd1);

        // T4: a request during WAIT is ignored.
        send(1'b0, 1'b0, 5'd20, 5'h00, 1'b0, 5'h00, 21);
        @(negedge clk);
        chk("busy_in_wait", 32'(busy), 32'd1);
        req = 1'b1; we = 1'b1; slot = 5'd9; wdata = 5'h07;
        @(posedge clk);
        #1 req = 1'b0;
        wait_ack(1'b0, lat);
        repeat (4) @(negedge clk);
        op(1'b0, 1'b0, 5'd9, 5'h00, 5'h00);

        // T5: 24-slot instance, top valid slot and an out-of-range slot.
        op(1'b1, 1'b1, 5'd23, 5'h11, 5'h00);
        op(1'b1, 1'b0, 5'd23, 5'h00, 5'h11);
        ld_cnt_b = 0;
        send(1'b1, 1'b1, 5'd30, 5'h1F, 1'b1, 5'h00, -1);
        wait_ack(1'b1, lat);
        chk("err_latency", 32'(lat), 32'd1);
        @(negedge clk);
        chk("err_ack_one_clk", 32'(ack_b), 32'd0);
        chk("err_no_load", 32'(ld_cnt_b), 32'd0);
        op(1'b1, 1'b0, 5'd23, 5'h00, 5'h11);
        op(1'b1, 1'b0, 5'd22, 5'h00, 5'h00);

        // T6: slow cen, counter wrap and sync, then reset while waiting.
        cen_div = 3;
        begin
            int t = 0;
            do begin @(negedge clk); t++; end while (slot_cnt != 5'd31 && t < 500);
            t = 0;
            do begin @(negedge clk); t++; end while (slot_cnt == 5'd31 && t < 500);
            if (t >= 500) timeout("wrap");
            chk("wrap_to_zero", 32'(slot_cnt), 32'd0);
            chk("sync_at_zero", 32'(sync), 32'd1);
            t = 0;
            do begin @(negedge clk); t++; end while (slot_cnt == 5'd0 && t < 500);
            chk("cnt_after_zero", 32'(slot_cnt), 32'd1);
            chk("sync_after_zero", 32'(sync), 32'd0);
        end
        op(1'b0, 1'b1, 5'd7, 5'h0F, 5'h00);
        op(1'b0, 1'b0, 5'd7, 5'h00, 5'h0F);
        send(1'b0, 1'b0, 5'd7, 5'h00, 1'b0, 5'h00, 8);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        qa.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wait_busy", 32'(busy), 32'd1);
        chk("rst_wait_cnt", 32'(slot_cnt), 32'd0);
        rst = 1'b0;
        wait_idle(1'b0, "reclear");
        op(1'b0, 1'b0, 5'd7, 5'h00, 5'h00);
        op(1'b0, 1'b0, 5'd5, 5'h00, 5'h00);
        op(1'b0, 1'b0, 5'd3, 5'h00, 5'h00);

        repeat (4) @(negedge clk);
        chk("queue_a_drained", 32'(qa.size()), 32'd0);
        chk("queue_b_drained", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
